// File: rtl/melody_sequencer.sv
// Melody sequencer: an 8-entry note queue feeding a play/rest/gap playback FSM.
// Each queue entry carries a note index, an octave shift and a duration in
// ticks. Pitched notes (0-11) raise enable for the whole duration. Notes 12-15
// are rests. A silent gap follows every played note or rest.
module melody_sequencer #(
  parameter int TICK_CYCLES = 500000,
  parameter int GAP_TICKS   = 2
) (
  input  logic        clk_50mhz,
  input  logic        reset,
  input  logic        wr_en,
  input  logic [14:0] wr_data,
  input  logic        flush,
  output logic [3:0]  note,
  output logic [2:0]  octave,
  output logic        enable,
  output logic        full,
  output logic        empty,
  output logic [3:0]  level,
  output logic        busy
);

  localparam int                PRE_W    = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  localparam logic [PRE_W-1:0]  PRE_MAX  = PRE_W'(TICK_CYCLES - 1);
  localparam logic [7:0]        GAP_LEN  = 8'(GAP_TICKS);
  localparam bit                HAS_GAP  = (GAP_TICKS > 0);

  typedef enum logic [1:0] {IDLE, PLAY, REST, GAP} state_t;

  state_t           state;
  logic [14:0]      mem [8];
  logic [2:0]       wr_ptr;
  logic [2:0]       rd_ptr;
  logic [PRE_W-1:0] pre;
  logic [7:0]       ticks;

  logic [14:0]      head;
  logic [3:0]       head_note;
  logic [2:0]       head_oct;
  logic [7:0]       head_dur;
  logic             head_pitched;
  logic             last_tick;
  logic             seg_end;
  logic             pop;
  logic             push;

  assign head         = mem[rd_ptr];
  assign head_note    = head[14:11];
  assign head_oct     = head[10:8];
  assign head_dur     = head[7:0];
  assign head_pitched = (head_note < 4'd12);

  // Final cycle of the current segment: last prescaler count of the last tick.
  assign last_tick = (pre == PRE_MAX) && (ticks == 8'd1);

  // A segment hands over to the next queue entry at the end of GAP, or at the
  // end of PLAY/REST when no gap is configured.
  always_comb begin
    seg_end = 1'b0;
    case (state)
      PLAY, REST: seg_end = last_tick && !HAS_GAP;
      GAP:        seg_end = last_tick;
      default:    seg_end = 1'b0;
    endcase
  end

  assign pop  = !empty && !flush && ((state == IDLE) || seg_end);
  assign push = wr_en && !full && !flush;
  assign busy = (state != IDLE);

  // Queue storage; entries are data only and need no reset.
  always_ff @(posedge clk_50mhz) begin
    if (push) mem[wr_ptr] <= wr_data;
  end

  // Queue pointers and registered occupancy flags.
  always_ff @(posedge clk_50mhz or posedge reset) begin
    if (reset) begin
      wr_ptr <= 3'd0;
      rd_ptr <= 3'd0;
      level  <= 4'd0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else if (flush) begin
      wr_ptr <= 3'd0;
      rd_ptr <= 3'd0;
      level  <= 4'd0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (push) wr_ptr <= wr_ptr + 3'd1;
      if (pop)  rd_ptr <= rd_ptr + 3'd1;
      case ({push, pop})
        2'b10: begin
          level <= level + 4'd1;
          full  <= (level == 4'd7);
          empty <= 1'b0;
        end
        2'b01: begin
          level <= level - 4'd1;
          full  <= 1'b0;
          empty <= (level == 4'd1);
        end
        default: ;
      endcase
    end
  end

  // Playback FSM with registered note/octave/enable and tick timing.
  always_ff @(posedge clk_50mhz or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      note   <= 4'd0;
      octave <= 3'd0;
      enable <= 1'b0;
      pre    <= '0;
      ticks  <= 8'd0;
    end else if (flush) begin
      state  <= IDLE;
      enable <= 1'b0;
      pre    <= '0;
      ticks  <= 8'd0;
    end else if (pop) begin
      if (head_dur == 8'd0) begin
        // Zero-length entries are consumed silently.
        state  <= IDLE;
        enable <= 1'b0;
      end else begin
        note   <= head_note;
        octave <= head_oct;
        state  <= head_pitched ? PLAY : REST;
        enable <= head_pitched;
        pre    <= '0;
        ticks  <= head_dur;
      end
    end else begin
      case (state)
        PLAY, REST: begin
          if (last_tick) begin
            enable <= 1'b0;
            if (HAS_GAP) begin
              state <= GAP;
              pre   <= '0;
              ticks <= GAP_LEN;
            end else begin
              state <= IDLE;
            end
          end else if (pre == PRE_MAX) begin
            pre   <= '0;
            ticks <= ticks - 8'd1;
          end else begin
            pre <= pre + 1'b1;
          end
        end
        GAP: begin
          if (last_tick) begin
            state <= IDLE;
          end else if (pre == PRE_MAX) begin
            pre   <= '0;
            ticks <= ticks - 8'd1;
          end else begin
            pre <= pre + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_melody_sequencer.sv
// Testbench for melody_sequencer: directed scenarios plus randomized traffic,
// checked every cycle against a queue-based behavioural model.
module tb_melody_sequencer;

  localparam int TC = 4;
  localparam int GT = 1;

  logic        clk_50mhz = 1'b0;
  logic        reset;
  logic        wr_en;
  logic [14:0] wr_data;
  logic        flush;
  logic [3:0]  note;
  logic [2:0]  octave;
  logic        enable;
  logic        full;
  logic        empty;
  logic [3:0]  level;
  logic        busy;

  melody_sequencer #(.TICK_CYCLES(TC), .GAP_TICKS(GT)) dut (
    .clk_50mhz(clk_50mhz),
    .reset    (reset),
    .wr_en    (wr_en),
    .wr_data  (wr_data),
    .flush    (flush),
    .note     (note),
    .octave   (octave),
    .enable   (enable),
    .full     (full),
    .empty    (empty),
    .level    (level),
    .busy     (busy)
  );

  always #5 clk_50mhz = ~clk_50mhz;

  int checks = 0;
  int errors = 0;

  // Model: queued entries, current activity (0 idle, 1 play, 2 rest, 3 gap),
  // cycles remaining in that activity, and the expected outputs.
  logic [14:0] q[$];
  int          m_mode;
  int          m_rem;
  logic [3:0]  m_note;
  logic [2:0]  m_oct;
  logic        m_en;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s obs=%0h exp=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [14:0] ent(input int n, input int o, input int d);
    return {4'(n), 3'(o), 8'(d)};
  endfunction

  task automatic model_reset();
    q.delete();
    m_mode = 0;
    m_rem  = 0;
    m_note = 4'd0;
    m_oct  = 3'd0;
    m_en   = 1'b0;
  endtask

  task automatic model_start(input logic [14:0] e);
    logic [14:0] v;
    int d;
    int n;
    v = e;
    d = int'(v[7:0]);
    n = int'(v[14:11]);
    if (d == 0) begin
      m_mode = 0;
      m_en   = 1'b0;
    end else begin
      m_note = v[14:11];
      m_oct  = v[10:8];
      m_mode = (n < 12) ? 1 : 2;
      m_en   = (n < 12);
      m_rem  = d * TC;
    end
  endtask

  // Advance the model by one clock edge using the inputs present at that edge.
  task automatic model_edge();
    int sz;
    if (reset) begin
      model_reset();
      return;
    end
    sz = q.size();
    if (flush) begin
      q.delete();
      m_mode = 0;
      m_en   = 1'b0;
      return;
    end
    if ((m_mode == 1 || m_mode == 2) && m_rem == 1 && GT > 0) begin
      m_mode = 3;
      m_rem  = GT * TC;
      m_en   = 1'b0;
    end else if (m_mode == 0 || m_rem == 1) begin
      if (sz > 0) model_start(q.pop_front());
      else begin
        m_mode = 0;
        m_en   = 1'b0;
      end
    end else begin
      m_rem--;
    end
    if (wr_en && sz < 8) q.push_back(wr_data);
  endtask

  task automatic compare_all();
    int sz;
    sz = q.size();
    check_val("note_oct", {note, octave}, {m_note, m_oct});
    check_val("enable", enable, m_en);
    check_val("level", level, sz);
    check_val("full_empty_busy", {full, empty, busy}, {sz == 8, sz == 0, m_mode != 0});
  endtask

  task automatic step();
    @(posedge clk_50mhz);
    model_edge();
    #1;
    compare_all();
  endtask

  task automatic write1(input logic [14:0] e);
    wr_en   = 1'b1;
    wr_data = e;
    step();
    wr_en   = 1'b0;
  endtask

  initial begin
    reset   = 1'b1;
    wr_en   = 1'b0;
    flush   = 1'b0;
    wr_data = 15'd0;
    model_reset();

    #2;
    check_val("rst_note_oct", {note, octave}, 7'd0);
    check_val("rst_enable", enable, 1'b0);
    check_val("rst_flags", {full, empty, busy}, 3'b010);
    check_val("rst_level", level, 4'd0);
    repeat (2) step();
    reset = 1'b0;
    repeat (2) step();

    // Single note {9,4,3}: cycle 0 is the write cycle.
    wr_en   = 1'b1;
    wr_data = ent(9, 4, 3);
    for (int c = 1; c <= 20; c++) begin
      step();
      wr_en = 1'b0;
      if (c >= 2 && c <= 13) begin
        check_val("t030_en", enable, 1'b1);
        check_val("t030_pitch", {note, octave}, {4'd9, 3'd4});
      end else if (c >= 14 && c <= 17) begin
        check_val("t030_gap", {enable, busy}, 2'b01);
      end else if (c >= 18) begin
        check_val("t030_idle", {enable, busy}, 2'b00);
      end
    end

    // Fill the queue behind a long note; the ninth write must be dropped.
    write1(ent(1, 2, 40));
    repeat (3) step();
    for (int k = 1; k <= 9; k++) begin
      wr_en   = 1'b1;
      wr_data = ent(k % 12, k % 8, 1 + (k % 3));
      step();
      if (k >= 8) check_val("t031_full", {full, level}, {1'b1, 4'd8});
    end
    wr_en = 1'b0;
    repeat (400) step();

    // Note, zero-length entry, rest, note.
    write1(ent(0, 3, 1));
    write1(ent(5, 3, 0));
    write1(ent(12, 0, 2));
    write1(ent(4, 3, 1));
    repeat (60) step();

    // Flush during PLAY with three entries queued and a colliding write.
    write1(ent(2, 1, 5));
    write1(ent(3, 1, 2));
    write1(ent(6, 2, 2));
    write1(ent(8, 2, 2));
    repeat (3) step();
    check_val("t033_pre_en", enable, 1'b1);
    flush   = 1'b1;
    wr_en   = 1'b1;
    wr_data = ent(7, 7, 7);
    step();
    flush = 1'b0;
    wr_en = 1'b0;
    check_val("t033_flush", {enable, empty, level, busy}, {1'b0, 1'b1, 4'd0, 1'b0});
    repeat (5) step();

    // Asynchronous reset between edges while a note plays.
    write1(ent(11, 5, 4));
    write1(ent(10, 6, 2));
    repeat (4) step();
    check_val("t034_pre_en", enable, 1'b1);
    #2;
    reset = 1'b1;
    #1;
    check_val("t034_en", enable, 1'b0);
    check_val("t034_pitch", {note, octave}, 7'd0);
    check_val("t034_flags", {full, empty, busy, level}, {3'b010, 4'd0});
    model_reset();
    step();
    reset = 1'b0;
    repeat (10) step();

    // Randomized traffic with occasional flushes.
    for (int i = 0; i < 3000; i++) begin
      wr_en   = ($urandom_range(0, 99) < 35);
      wr_data = {4'($urandom_range(0, 15)), 3'($urandom), 8'($urandom_range(0, 3))};
      flush   = ($urandom_range(0, 199) == 0);
      step();
    end
    wr_en = 1'b0;
    flush = 1'b0;
    repeat (100) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/melody_sequencer.md
MELODY_SEQUENCER -- requirements
Module: melody_sequencer

Interface
REQ-001 SHALL have parameter TICK_CYCLES, default 500000, meaning clk_50mhz cycles per duration tick (10 ms).
REQ-002 SHALL have parameter GAP_TICKS, default 2, meaning silent ticks inserted after each played note or rest.
REQ-003 SHALL have port clk_50mhz  input  1  sole clock; all logic on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port wr_en  input  1  write strobe; one queue entry per cycle.
REQ-006 SHALL have port wr_data  input  15  entry: [14:11] note, [10:8] octave, [7:0] duration in ticks.
REQ-007 SHALL have port flush  input  1  synchronous clear of the queue and playback.
REQ-008 SHALL have port note  output  4  note index to the buzzer stage (0=C ... 11=B).
REQ-009 SHALL have port octave  output  3  octave shift to the buzzer stage.
REQ-010 SHALL have port enable  output  1  buzzer enable; high only while a pitched note plays.
REQ-011 SHALL have port full  output  1  queue holds 8 entries.
REQ-012 SHALL have port empty  output  1  queue holds 0 entries.
REQ-013 SHALL have port level  output  4  entry count, 0..8.
REQ-014 SHALL have port busy  output  1  high in any state other than IDLE.

Function
REQ-015 SHALL buffer entries in an 8-deep FIFO with 3-bit wrapping read/write pointers; full, empty and level are registered and consistent every cycle.
REQ-016 SHALL accept a write only when wr_en=1, full=0 and flush=0; a write while full SHALL be dropped, even if a pop occurs in the same cycle.
REQ-017 SHALL, on a simultaneous accepted write and pop, leave level unchanged.
REQ-018 SHALL implement states IDLE, PLAY, REST and GAP.
REQ-019 SHALL, in IDLE with empty=0, pop the head entry; the next cycle enters PLAY (note 0-11) or REST (note 12-15) with note and octave loaded from the entry.
REQ-020 SHALL discard a popped entry with duration 0 and remain in IDLE; outputs unchanged, no gap.
REQ-021 SHALL drive enable=1 for exactly duration*TICK_CYCLES cycles in PLAY; REST holds enable=0 for the same length.
REQ-022 SHALL restart the tick prescaler at 0 on entry to PLAY, REST or GAP, so lengths are exact multiples of TICK_CYCLES.
REQ-023 SHALL then enter GAP for GAP_TICKS*TICK_CYCLES cycles with enable=0; if GAP_TICKS=0, GAP is skipped.
REQ-024 SHALL, on the last GAP cycle (or last PLAY/REST cycle when GAP is skipped), pop the next entry if empty=0 and continue without an IDLE cycle; otherwise go to IDLE.
REQ-025 SHALL hold note and octave at their last values outside PLAY/REST.
REQ-026 SHALL treat flush as highest priority: next cycle is IDLE with the FIFO empty, level=0 and enable=0; a same-cycle write is dropped.
REQ-027 SHALL use a duration counter of at least 8 bits and a prescaler sized for TICK_CYCLES-1; neither counter overflows.

Reset
REQ-028 SHALL, while reset=1, immediately force IDLE, note=0, octave=0, enable=0, full=0, empty=1, level=0, busy=0, pointers and counters to 0, regardless of clock.
REQ-029 SHALL discard any note in progress on reset; playback resumes only after new writes.

Verification (TICK_CYCLES=4, GAP_TICKS=1)
REQ-030 SHALL test: write {note 9, octave 4, dur 3} at cycle 0 into an idle queue -> enable=1, note=9, octave=4 during cycles 2-13; enable=0 during cycles 14-17; busy=0 from cycle 18.
REQ-031 SHALL test: 9 consecutive writes with playback held by a long first note -> full=1, level=8 after the 8th write; the 9th write is dropped; 8 notes play in write order.
REQ-032 SHALL test: entries {C dur 1}, {dur 0}, {note 12 dur 2}, {E dur 1} -> C high 4 cycles, gap 4, the zero-duration entry is skipped, rest low 8 with busy=1, gap 4, then E high 4.
REQ-033 SHALL test: flush asserted in the middle of PLAY with 3 entries queued -> next cycle enable=0, empty=1, level=0, busy=0.
REQ-034 SHALL test: reset asserted between clock edges during PLAY -> enable=0 and all outputs at reset values before the next edge; no output until new writes.
